// File: rtl/arbitro_ie_if.sv
// Requester/arbiter bundle for arbitro_ie.
// master = requester side, slave = arbiter side.
interface arbitro_ie_if;
    logic       REQ_IE01;
    logic       REQ_IE02;
    logic [1:0] PERF_IE01;
    logic [1:0] PERF_IE02;
    logic       GNT_IE01;
    logic       GNT_IE02;
    logic       TIMEOUT;
    logic       STARVE_OVR;

    modport master (
        output REQ_IE01, REQ_IE02,
        output PERF_IE01, PERF_IE02,
        input  GNT_IE01, GNT_IE02,
        input  TIMEOUT, STARVE_OVR
    );

    modport slave (
        input  REQ_IE01, REQ_IE02,
        input  PERF_IE01, PERF_IE02,
        output GNT_IE01, GNT_IE02,
        output TIMEOUT, STARVE_OVR
    );
endinterface

// File: rtl/arbitro_ie.sv
// Two-way registered arbiter for IE01/IE02 with hold limit,
// timeout penalty and starvation override.
module arbitro_ie #(
    parameter int MAX_HOLD     = 8,
    parameter int STARVE_LIMIT = 3
) (
    input logic         clk,
    input logic         rst,
    arbitro_ie_if.slave bus
);
    localparam int HW = $clog2(MAX_HOLD);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
    localparam logic [SW-1:0] LIM = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE,
        GRANT1,
        GRANT2
    } state_t;

    state_t        state, state_nxt;
    logic [HW-1:0] hold_cnt, hold_nxt;
    logic [SW-1:0] starve01, starve01_nxt;
    logic [SW-1:0] starve02, starve02_nxt;
    logic          pen01, pen01_nxt;
    logic          pen02, pen02_nxt;
    logic          gnt1, gnt2;
    logic          timeout, timeout_nxt;
    logic          sovr, sovr_nxt;
    logic          pick2;
    logic          both;

    assign both = bus.REQ_IE01 && bus.REQ_IE02;

    always_comb begin
        state_nxt    = state;
        hold_nxt     = hold_cnt;
        starve01_nxt = starve01;
        starve02_nxt = starve02;
        pen01_nxt    = pen01;
        pen02_nxt    = pen02;
        timeout_nxt  = 1'b0;
        sovr_nxt     = 1'b0;
        pick2        = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.REQ_IE01 || bus.REQ_IE02) begin
                    // first matching rule decides the winner
                    if (!bus.REQ_IE02) begin
                        pick2 = 1'b0;
                    end else if (!bus.REQ_IE01) begin
                        pick2 = 1'b1;
                    end else if (starve01 == LIM) begin
                        pick2    = 1'b0;
                        sovr_nxt = 1'b1;
                    end else if (starve02 == LIM) begin
                        pick2    = 1'b1;
                        sovr_nxt = 1'b1;
                    end else if (pen01) begin
                        pick2 = 1'b1;
                    end else if (pen02) begin
                        pick2 = 1'b0;
                    end else begin
                        pick2 = bus.PERF_IE01 < bus.PERF_IE02;
                    end
                    state_nxt = pick2 ? GRANT2 : GRANT1;
                    hold_nxt  = '0;
                    pen01_nxt = 1'b0;
                    pen02_nxt = 1'b0;
                    if (pick2) begin
                        starve02_nxt = '0;
                        if (both && starve01 != LIM)
                            starve01_nxt = starve01 + SW'(1);
                    end else begin
                        starve01_nxt = '0;
                        if (both && starve02 != LIM)
                            starve02_nxt = starve02 + SW'(1);
                    end
                end
            end
            GRANT1: begin
                if (!bus.REQ_IE01) begin
                    state_nxt = IDLE;
                end else if (hold_cnt == HOLD_LAST) begin
                    state_nxt   = IDLE;
                    timeout_nxt = 1'b1;
                    pen01_nxt   = 1'b1;
                end else begin
                    hold_nxt = hold_cnt + HW'(1);
                end
            end
            GRANT2: begin
                if (!bus.REQ_IE02) begin
                    state_nxt = IDLE;
                end else if (hold_cnt == HOLD_LAST) begin
                    state_nxt   = IDLE;
                    timeout_nxt = 1'b1;
                    pen02_nxt   = 1'b1;
                end else begin
                    hold_nxt = hold_cnt + HW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            hold_cnt <= '0;
            starve01 <= '0;
            starve02 <= '0;
            pen01    <= 1'b0;
            pen02    <= 1'b0;
            gnt1     <= 1'b0;
            gnt2     <= 1'b0;
            timeout  <= 1'b0;
            sovr     <= 1'b0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_nxt;
            starve01 <= starve01_nxt;
            starve02 <= starve02_nxt;
            pen01    <= pen01_nxt;
            pen02    <= pen02_nxt;
            gnt1     <= state_nxt == GRANT1;
            gnt2     <= state_nxt == GRANT2;
            timeout  <= timeout_nxt;
            sovr     <= sovr_nxt;
        end
    end

    assign bus.GNT_IE01   = gnt1;
    assign bus.GNT_IE02   = gnt2;
    assign bus.TIMEOUT    = timeout;
    assign bus.STARVE_OVR = sovr;
endmodule

// File: tb/tb_arbitro_ie.sv
// Directed scenarios plus random traffic for arbitro_ie,
// checked cycle by cycle against an owner/usage model.
module tb_arbitro_ie;
    localparam int MH = 4;
    localparam int SL = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    arbitro_ie_if bus ();

    arbitro_ie #(
        .MAX_HOLD    (MH),
        .STARVE_LIMIT(SL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    int m_owner;
    int m_used;
    int m_st[1:2];
    bit m_pen[1:2];
    bit m_to;
    bit m_so;

    task automatic chk(input string tag,
                       input logic obs, input logic exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b t=%0t",
                   tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, r1, r2,
                              input int p1, p2);
        int w;
        bit rq[1:2];
        rq[1] = r1;
        rq[2] = r2;
        m_to = 0;
        m_so = 0;
        if (r) begin
            m_owner = 0;
            m_used  = 0;
            m_st    = '{0, 0};
            m_pen   = '{0, 0};
        end else if (m_owner == 0) begin
            if (r1 || r2) begin
                if (!r2) w = 1;
                else if (!r1) w = 2;
                else if (m_st[1] == SL) begin w = 1; m_so = 1; end
                else if (m_st[2] == SL) begin w = 2; m_so = 1; end
                else if (m_pen[1]) w = 2;
                else if (m_pen[2]) w = 1;
                else w = (p1 >= p2) ? 1 : 2;
                if (r1 && r2 && m_st[3-w] < SL)
                    m_st[3-w]++;
                m_st[w] = 0;
                m_pen   = '{0, 0};
                m_owner = w;
                m_used  = 1;
            end
        end else if (!rq[m_owner]) begin
            m_owner = 0;
        end else if (m_used == MH) begin
            m_to = 1;
            m_pen[m_owner] = 1;
            m_owner = 0;
        end else begin
            m_used++;
        end
    endtask

    task automatic cyc(input bit r, r1, r2,
                       input logic [1:0] p1, p2);
        rst = r;
        bus.REQ_IE01  = r1;
        bus.REQ_IE02  = r2;
        bus.PERF_IE01 = p1;
        bus.PERF_IE02 = p2;
        @(posedge clk);
        model_step(r, r1, r2, int'(p1), int'(p2));
        #1;
        chk("gnt01", bus.GNT_IE01, m_owner == 1);
        chk("gnt02", bus.GNT_IE02, m_owner == 2);
        chk("timeout", bus.TIMEOUT, m_to);
        chk("starve_ovr", bus.STARVE_OVR, m_so);
        chk("onehot", !(bus.GNT_IE01 && bus.GNT_IE02), 1'b1);
    endtask

    initial begin
        bit r1, r2;
        m_owner = 0;
        m_used  = 0;
        m_st    = '{0, 0};
        m_pen   = '{0, 0};
        m_to    = 0;
        m_so    = 0;

        // reset with both requesting
        cyc(1, 1, 1, 2, 1);
        cyc(1, 1, 1, 2, 1);
        chk("rst_gnt01", bus.GNT_IE01, 1'b0);
        chk("rst_timeout", bus.TIMEOUT, 1'b0);
        cyc(0, 1, 1, 2, 1);
        chk("rel_gnt01", bus.GNT_IE01, 1'b1);

        // tie goes to IE01, then IE02 after one idle cycle
        cyc(1, 0, 0, 1, 1);
        for (int i = 0; i < 3; i++) cyc(0, 1, 1, 1, 1);
        chk("tie_gnt01", bus.GNT_IE01, 1'b1);
        cyc(0, 0, 1, 1, 1);
        chk("tie_idle02", bus.GNT_IE02, 1'b0);
        cyc(0, 0, 1, 1, 1);
        chk("tie_gnt02", bus.GNT_IE02, 1'b1);

        // timeout and penalty
        cyc(1, 0, 0, 3, 0);
        for (int i = 1; i <= 12; i++) begin
            cyc(0, 1, 1, 3, 0);
            if (i == 5) chk("to1_pulse", bus.TIMEOUT, 1'b1);
            if (i == 6) chk("pen_gnt02", bus.GNT_IE02, 1'b1);
            if (i == 10) chk("to2_pulse", bus.TIMEOUT, 1'b1);
            if (i == 11) chk("regnt01", bus.GNT_IE01, 1'b1);
        end

        // starvation override
        cyc(1, 0, 0, 3, 0);
        for (int k = 0; k < 2; k++) begin
            cyc(0, 1, 1, 3, 0);
            chk("stv_win01", bus.GNT_IE01, 1'b1);
            cyc(0, 1, 1, 3, 0);
            cyc(0, 0, 1, 3, 0);
        end
        cyc(0, 1, 1, 3, 0);
        chk("stv_gnt02", bus.GNT_IE02, 1'b1);
        chk("stv_ovr", bus.STARVE_OVR, 1'b1);
        cyc(0, 1, 1, 3, 0);
        chk("stv_ovr_end", bus.STARVE_OVR, 1'b0);

        // reset mid-grant
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0);
        cyc(1, 0, 1, 0, 0);
        chk("mid_rst_gnt02", bus.GNT_IE02, 1'b0);
        cyc(0, 1, 1, 3, 0);
        chk("post_rst_gnt01", bus.GNT_IE01, 1'b1);

        // single requester
        cyc(1, 0, 0, 0, 0);
        for (int i = 1; i <= 7; i++) begin
            cyc(0, 0, 1, 3, 0);
            if (i == 1) chk("single_gnt02", bus.GNT_IE02, 1'b1);
            if (i == 5) chk("single_to", bus.TIMEOUT, 1'b1);
        end

        // random traffic
        r1 = 0;
        r2 = 0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(3) == 0) r1 = ~r1;
            if ($urandom_range(3) == 0) r2 = ~r2;
            cyc($urandom_range(49) == 0, r1, r2,
                2'($urandom_range(3)), 2'($urandom_range(3)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
